// File: rtl/ext_io_pkg.sv
// Shared definitions for the external I/O bridge: register map, alarm states,
// counter width and the status-word helper.
package ext_io_pkg;

  localparam int COUNTER_WIDTH = 48;

  localparam int ADDR_PINS     = 'h0;
  localparam int ADDR_MASK     = 'h1;
  localparam int ADDR_COUNT_LO = 'h2;
  localparam int ADDR_SNAP_MID = 'h3;
  localparam int ADDR_SNAP_HI  = 'h4;
  localparam int ADDR_ALARM    = 'h5;
  localparam int ADDR_CLEAR    = 'h6;

  typedef enum logic [1:0] {
    ALARM_IDLE,
    ALARM_ARMED,
    ALARM_EXPIRED
  } alarm_state_t;

  function automatic logic [1:0] alarm_status(input alarm_state_t state);
    return {state == ALARM_EXPIRED, state == ALARM_ARMED};
  endfunction

endpackage

// File: rtl/ext_io_bridge_if.sv
// External memory port of the bridge: one access per clock, direction set by write_enable.
interface ext_io_bridge_if #(
  parameter int P_DATA_WIDTH    = 16,
  parameter int P_ADDRESS_WIDTH = 4
);
  logic [P_DATA_WIDTH-1:0]    wr_data;
  logic [P_ADDRESS_WIDTH-1:0] address;
  logic                       write_enable;
  logic [P_DATA_WIDTH-1:0]    rd_data;

  modport master (
    output wr_data,
    output address,
    output write_enable,
    input  rd_data
  );

  modport slave (
    input  wr_data,
    input  address,
    input  write_enable,
    output rd_data
  );
endinterface

// File: rtl/ext_io_us_timebase.sv
// Microsecond timebase: prescaler producing a one-cycle tick and a free-running
// 48-bit microsecond counter that wraps to zero.
module ext_io_us_timebase
  import ext_io_pkg::*;
#(
  parameter int P_CLK_CYCLES_PER_US = 50
) (
  input  logic                     clk,
  input  logic                     nreset,
  output logic                     tick,
  output logic [COUNTER_WIDTH-1:0] count
);
  localparam int PW = $clog2(P_CLK_CYCLES_PER_US);

  logic [PW-1:0]            prescale_reg;
  logic [COUNTER_WIDTH-1:0] count_reg;

  assign tick  = (prescale_reg == PW'(P_CLK_CYCLES_PER_US - 1));
  assign count = count_reg;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      prescale_reg <= '0;
      count_reg    <= '0;
    end else if (tick) begin
      prescale_reg <= '0;
      count_reg    <= count_reg + COUNTER_WIDTH'(1);
    end else begin
      prescale_reg <= prescale_reg + PW'(1);
    end
  end

endmodule

// File: rtl/ext_io_bridge.sv
// Memory-mapped external I/O bridge: open-drain bit-bang lines with synchronised
// readback, tear-free 48-bit microsecond counter reads and a one-shot alarm.
module ext_io_bridge
  import ext_io_pkg::*;
#(
  parameter int P_DATA_WIDTH        = 16,
  parameter int P_ADDRESS_WIDTH     = 4,
  parameter int P_NUM_OD_CHANNELS   = 2,
  parameter int P_CLK_CYCLES_PER_US = 50
) (
  input  logic                         clk,
  input  logic                         nreset,
  ext_io_bridge_if.slave               bus,
  inout  wire  [P_NUM_OD_CHANNELS-1:0] od,
  output logic                         alarm
);
  localparam int DW = P_DATA_WIDTH;
  localparam int AW = P_ADDRESS_WIDTH;
  localparam int N  = P_NUM_OD_CHANNELS;
  localparam int SW = COUNTER_WIDTH - DW;

  logic                     tick;
  logic [COUNTER_WIDTH-1:0] count;

  logic [N-1:0]  mask_reg;
  logic [N-1:0]  sync1_reg;
  logic [N-1:0]  sync2_reg;
  logic [SW-1:0] snap_reg;
  logic [DW-1:0] rd_data_reg;
  logic [DW-1:0] rd_next;
  logic [DW-1:0] remaining_reg;
  alarm_state_t  state_reg;
  logic          alarm_reg;

  logic rd_en;
  logic mask_wr;
  logic arm_wr;
  logic clear_wr;
  logic snap_rd;

  ext_io_us_timebase #(
    .P_CLK_CYCLES_PER_US(P_CLK_CYCLES_PER_US)
  ) u_timebase (
    .clk   (clk),
    .nreset(nreset),
    .tick  (tick),
    .count (count)
  );

  assign rd_en    = !bus.write_enable;
  assign mask_wr  = bus.write_enable && (bus.address == AW'(ADDR_PINS));
  assign arm_wr   = bus.write_enable && (bus.address == AW'(ADDR_ALARM));
  assign clear_wr = bus.write_enable && (bus.address == AW'(ADDR_CLEAR));
  assign snap_rd  = rd_en && (bus.address == AW'(ADDR_COUNT_LO));

  // A released line floats and relies on the external pull-up.
  for (genvar gi = 0; gi < N; gi++) begin : g_channel
    assign od[gi] = mask_reg[gi] ? 1'bz : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      mask_reg  <= '1;
      sync1_reg <= '1;
      sync2_reg <= '1;
    end else begin
      if (mask_wr) begin
        mask_reg <= bus.wr_data[N-1:0];
      end
      sync1_reg <= od;
      sync2_reg <= sync1_reg;
    end
  end

  always_comb begin
    rd_next = '0;
    case (bus.address)
      AW'(ADDR_PINS):     rd_next = DW'(sync2_reg);
      AW'(ADDR_MASK):     rd_next = DW'(mask_reg);
      AW'(ADDR_COUNT_LO): rd_next = count[DW-1:0];
      AW'(ADDR_SNAP_MID): rd_next = snap_reg[DW-1:0];
      AW'(ADDR_SNAP_HI):  rd_next = snap_reg[SW-1:DW];
      AW'(ADDR_ALARM):    rd_next = DW'(alarm_status(state_reg));
      default:            rd_next = '0;
    endcase
  end

  // The upper words are captured on the same edge as the live low word, so a
  // following 0x3/0x4 read pair can never straddle a carry.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      rd_data_reg <= '0;
      snap_reg    <= '0;
    end else begin
      if (rd_en) begin
        rd_data_reg <= rd_next;
      end
      if (snap_rd) begin
        snap_reg <= count[COUNTER_WIDTH-1:DW];
      end
    end
  end

  assign bus.rd_data = rd_data_reg;

  // Arm has top priority; a clear only matters once the alarm has expired.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_reg     <= ALARM_IDLE;
      remaining_reg <= '0;
      alarm_reg     <= 1'b0;
    end else if (arm_wr) begin
      state_reg     <= ALARM_ARMED;
      remaining_reg <= bus.wr_data;
      alarm_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ALARM_ARMED: begin
          if (remaining_reg == '0) begin
            state_reg <= ALARM_EXPIRED;
            alarm_reg <= 1'b1;
          end else if (tick) begin
            if (remaining_reg == DW'(1)) begin
              state_reg <= ALARM_EXPIRED;
              alarm_reg <= 1'b1;
            end
            remaining_reg <= remaining_reg - DW'(1);
          end
        end
        ALARM_EXPIRED: begin
          if (clear_wr) begin
            state_reg <= ALARM_IDLE;
            alarm_reg <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign alarm = alarm_reg;

endmodule

// File: tb/tb_ext_io_bridge.sv
// Self-checking bench for ext_io_bridge: randomized bus traffic against a
// behavioural model of pins, microsecond counter and alarm timing.
module tb_ext_io_bridge;
  localparam int P  = 50;
  localparam int N  = 2;
  localparam logic [3:0] IDLE_ADDR = 4'hF;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic [N-1:0] ext_low = '0;
  wire  [N-1:0] od;
  logic alarm;

  int tests = 0;
  int fails = 0;
  int unsigned cyc = 0;
  int unsigned last_rd_cyc = 0;

  ext_io_bridge_if #(.P_DATA_WIDTH(16), .P_ADDRESS_WIDTH(4)) bus_if ();

  ext_io_bridge #(
    .P_DATA_WIDTH       (16),
    .P_ADDRESS_WIDTH    (4),
    .P_NUM_OD_CHANNELS  (N),
    .P_CLK_CYCLES_PER_US(P)
  ) dut (
    .clk   (clk),
    .nreset(nreset),
    .bus   (bus_if),
    .od    (od),
    .alarm (alarm)
  );

  // External world: pull-ups plus an optional device pulling each line low.
  for (genvar gi = 0; gi < N; gi++) begin : g_pin
    pullup (od[gi]);
    assign od[gi] = ext_low[gi] ? 1'b0 : 1'bz;
  end

  always #5 clk = ~clk;

  // Edges elapsed since reset release: the reference for the microsecond counter.
  always @(posedge clk) begin
    if (!nreset) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  initial begin
    #10000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic bus_read(input logic [3:0] addr, output logic [15:0] data);
    @(negedge clk);
    bus_if.address      = addr;
    bus_if.write_enable = 1'b0;
    last_rd_cyc         = cyc;
    @(posedge clk);
    #1;
    data = bus_if.rd_data;
    bus_if.address = IDLE_ADDR;
    $display("[TB] rd addr=0x%h data=0x%h", addr, data);
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [15:0] data);
    @(negedge clk);
    bus_if.address      = addr;
    bus_if.wr_data      = data;
    bus_if.write_enable = 1'b1;
    @(posedge clk);
    #1;
    bus_if.write_enable = 1'b0;
    bus_if.address      = IDLE_ADDR;
    $display("[TB] wr addr=0x%h data=0x%h", addr, data);
  endtask

  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
    $display("[TB] reset applied");
  endtask

  task automatic test_reset();
    logic [15:0] d;
    ext_low = '0;
    do_reset();
    tests++;
    if (bus_if.rd_data !== 16'h0000) begin
      fails++; $display("[TB] FAIL reset_rd_data: got 0x%h expected 0x0000", bus_if.rd_data);
    end
    tests++;
    if (alarm !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_alarm: got %b expected 0", alarm);
    end
    tests++;
    if (od !== 2'b11) begin
      fails++; $display("[TB] FAIL reset_pins: got %b expected 11", od);
    end
    bus_read(4'h0, d);
    tests++;
    if (d !== 16'h0003) begin
      fails++; $display("[TB] FAIL reset_pin_read: got 0x%h expected 0x0003", d);
    end
    bus_read(4'h1, d);
    tests++;
    if (d !== 16'h0003) begin
      fails++; $display("[TB] FAIL reset_mask_read: got 0x%h expected 0x0003", d);
    end
    bus_read(4'h5, d);
    tests++;
    if (d !== 16'h0000) begin
      fails++; $display("[TB] FAIL reset_status_read: got 0x%h expected 0x0000", d);
    end
  endtask

  task automatic test_pins();
    logic [15:0] d;
    logic [15:0] m;
    logic [N-1:0] exp_pin;
    // Mask 0x0002: line 0 pulled low, line 1 released.
    ext_low = '0;
    bus_write(4'h0, 16'h0002);
    tests++;
    if (od !== 2'b10) begin
      fails++; $display("[TB] FAIL mask2_pins: got %b expected 10", od);
    end
    repeat (2) @(posedge clk);
    bus_read(4'h0, d);
    tests++;
    if (d !== 16'h0002) begin
      fails++; $display("[TB] FAIL mask2_pin_read: got 0x%h expected 0x0002", d);
    end
    for (int i = 0; i < 6; i++) begin
      m       = 16'($urandom);
      ext_low = N'($urandom_range(0, 3));
      exp_pin = m[N-1:0] & ~ext_low;
      bus_write(4'h0, m);
      tests++;
      if (od !== exp_pin) begin
        fails++; $display("[TB] FAIL rand_pins: got %b expected %b", od, exp_pin);
      end
      repeat (2) @(posedge clk);
      bus_read(4'h0, d);
      tests++;
      if (d !== {14'd0, exp_pin}) begin
        fails++; $display("[TB] FAIL rand_pin_read: got 0x%h expected 0x%h", d, {14'd0, exp_pin});
      end
      bus_read(4'h1, d);
      tests++;
      if (d !== (m & 16'h0003)) begin
        fails++; $display("[TB] FAIL rand_mask_read: got 0x%h expected 0x%h", d, m & 16'h0003);
      end
    end
    // Synchroniser latency: external pull-down on a released line.
    ext_low = '0;
    bus_write(4'h0, 16'h0003);
    repeat (4) @(posedge clk);
    @(negedge clk);
    ext_low = 2'b01;
    @(posedge clk);
    bus_read(4'h0, d);
    tests++;
    if (d !== 16'h0003) begin
      fails++; $display("[TB] FAIL sync_early: got 0x%h expected 0x0003", d);
    end
    @(negedge clk);
    ext_low = 2'b10;
    repeat (2) @(posedge clk);
    bus_read(4'h0, d);
    tests++;
    if (d !== 16'h0001) begin
      fails++; $display("[TB] FAIL sync_on_time: got 0x%h expected 0x0001", d);
    end
    ext_low = '0;
  endtask

  task automatic test_unmapped();
    logic [15:0] d;
    logic [15:0] held;
    logic [3:0] a;
    bus_write(4'h0, 16'h0001);
    bus_read(4'h1, held);
    // Read data must hold across a write cycle; writes to read-only/unmapped are ignored.
    for (int i = 1; i <= 4; i++) begin
      bus_write(4'(i), 16'h0002);
      tests++;
      if (bus_if.rd_data !== held) begin
        fails++; $display("[TB] FAIL hold_on_write: got 0x%h expected 0x%h", bus_if.rd_data, held);
      end
    end
    bus_write(4'h7, 16'hFFFE);
    bus_write(4'hF, 16'hFFFE);
    bus_read(4'h1, d);
    tests++;
    if (d !== 16'h0001) begin
      fails++; $display("[TB] FAIL ro_write_ignored: got 0x%h expected 0x0001", d);
    end
    for (int i = 0; i < 4; i++) begin
      a = 4'($urandom_range(7, 15));
      bus_read(4'h1, d);
      bus_read(a, d);
      tests++;
      if (d !== 16'h0000) begin
        fails++; $display("[TB] FAIL unmapped_read: got 0x%h expected 0x0000", d);
      end
    end
    bus_write(4'h0, 16'h0003);
  endtask

  task automatic test_counter();
    logic [15:0] d;
    int unsigned us;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 300)) @(posedge clk);
      bus_read(4'h2, d);
      us = last_rd_cyc / P;
      tests++;
      if (d !== 16'(us)) begin
        fails++; $display("[TB] FAIL counter_lo: got 0x%h expected 0x%h", d, 16'(us));
      end
    end
    bus_read(4'h3, d);
    tests++;
    if (d !== 16'(us >> 16)) begin
      fails++; $display("[TB] FAIL counter_mid: got 0x%h expected 0x%h", d, 16'(us >> 16));
    end
  endtask

  task automatic test_snapshot();
    logic [15:0] d;
    logic [15:0] exp [6];
    // Counter preset at prescaler phase 0; read 0x2 on the edge where it ticks.
    do @(negedge clk); while ((cyc % P) != 0);
    force dut.u_timebase.count_reg = 48'h0000_FFFF_FFFE;
    #1 release dut.u_timebase.count_reg;
    repeat (P - 1) @(posedge clk);
    bus_read(4'h2, d);
    tests++;
    if (d !== 16'hFFFE) begin
      fails++; $display("[TB] FAIL snap1_lo: got 0x%h expected 0xfffe", d);
    end
    bus_read(4'h3, d);
    tests++;
    if (d !== 16'hFFFF) begin
      fails++; $display("[TB] FAIL snap1_mid: got 0x%h expected 0xffff", d);
    end
    bus_read(4'h4, d);
    tests++;
    if (d !== 16'h0000) begin
      fails++; $display("[TB] FAIL snap1_hi: got 0x%h expected 0x0000", d);
    end
    // Same again across the carry into bit 32.
    do @(negedge clk); while ((cyc % P) != 0);
    force dut.u_timebase.count_reg = 48'h0000_FFFF_FFFF;
    #1 release dut.u_timebase.count_reg;
    repeat (P - 1) @(posedge clk);
    exp = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0001};
    for (int i = 0; i < 6; i++) begin
      bus_read(4'(2 + (i % 3)), d);
      tests++;
      if (d !== exp[i]) begin
        fails++; $display("[TB] FAIL snap2_word%0d: got 0x%h expected 0x%h", i, d, exp[i]);
      end
    end
    // Wrap from all ones: preset just before a tick.
    do @(negedge clk); while ((cyc % P) != P - 1);
    force dut.u_timebase.count_reg = 48'hFFFF_FFFF_FFFF;
    #1 release dut.u_timebase.count_reg;
    for (int i = 0; i < 3; i++) begin
      bus_read(4'(2 + i), d);
      tests++;
      if (d !== 16'h0000) begin
        fails++; $display("[TB] FAIL wrap_word%0d: got 0x%h expected 0x0000", i, d);
      end
    end
  endtask

  // Arms with delay dly and checks the rise against the tick-quantised window.
  task automatic arm_and_check(input int dly, input string name);
    int lat;
    int lo;
    int hi;
    lo  = (dly - 1) * P + 1;
    hi  = dly * P + 1;
    lat = 0;
    bus_write(4'h5, 16'(dly));
    for (int k = 1; k <= hi + 20; k++) begin
      @(posedge clk);
      #1;
      if (alarm === 1'b1) begin
        lat = k;
        break;
      end
    end
    tests++;
    if (lat < lo || lat > hi) begin
      fails++; $display("[TB] FAIL %s: got latency %0d expected %0d..%0d", name, lat, lo, hi);
    end else begin
      $display("[TB] alarm D=%0d rose after %0d cycles", dly, lat);
    end
  endtask

  task automatic test_alarm();
    logic [15:0] d;
    int highs;
    arm_and_check(3, "alarm_d3");
    bus_read(4'h5, d);
    tests++;
    if (d !== 16'h0002) begin
      fails++; $display("[TB] FAIL status_expired: got 0x%h expected 0x0002", d);
    end
    bus_write(4'h6, 16'h1234);
    tests++;
    if (alarm !== 1'b0) begin
      fails++; $display("[TB] FAIL clear_falls: got %b expected 0", alarm);
    end
    for (int i = 0; i < 3; i++) begin
      arm_and_check($urandom_range(1, 4), "alarm_rand");
      bus_write(4'h6, 16'(0));
      bus_read(4'h5, d);
      tests++;
      if (d !== 16'h0000 || alarm !== 1'b0) begin
        fails++; $display("[TB] FAIL rand_clear: got 0x%h/%b expected 0x0000/0", d, alarm);
      end
    end
    // Zero delay expires on the edge after the arm.
    bus_write(4'h5, 16'h0000);
    tests++;
    if (alarm !== 1'b0) begin
      fails++; $display("[TB] FAIL d0_arm_edge: got %b expected 0", alarm);
    end
    @(posedge clk);
    #1;
    tests++;
    if (alarm !== 1'b1) begin
      fails++; $display("[TB] FAIL d0_next_edge: got %b expected 1", alarm);
    end
    // Re-arm from EXPIRED drops the level at once.
    bus_write(4'h5, 16'h0002);
    bus_read(4'h5, d);
    tests++;
    if (alarm !== 1'b0 || d !== 16'h0001) begin
      fails++; $display("[TB] FAIL rearm_expired: got %b/0x%h expected 0/0x0001", alarm, d);
    end
    // Clear while ARMED is ignored.
    bus_write(4'h6, 16'hFFFF);
    bus_read(4'h5, d);
    tests++;
    if (d !== 16'h0001) begin
      fails++; $display("[TB] FAIL clear_armed: got 0x%h expected 0x0001", d);
    end
    bus_write(4'h6, 16'h0);
    // Re-arm mid-count: expiry follows the new D = 1 window.
    bus_write(4'h5, 16'h0005);
    repeat ($urandom_range(10, 150)) @(posedge clk);
    #1;
    tests++;
    if (alarm !== 1'b0) begin
      fails++; $display("[TB] FAIL d5_not_yet: got %b expected 0", alarm);
    end
    arm_and_check(1, "rearm_d1");
    bus_write(4'h6, 16'h0);
    // Reset while ARMED aborts the alarm.
    bus_write(4'h5, 16'h0004);
    repeat (30) @(posedge clk);
    do_reset();
    bus_read(4'h5, d);
    tests++;
    if (d !== 16'h0000) begin
      fails++; $display("[TB] FAIL reset_abort_status: got 0x%h expected 0x0000", d);
    end
    highs = 0;
    for (int k = 0; k < 5 * P; k++) begin
      @(posedge clk);
      #1;
      if (alarm !== 1'b0) highs++;
    end
    tests++;
    if (highs != 0) begin
      fails++; $display("[TB] FAIL reset_abort_alarm: got %0d high cycles expected 0", highs);
    end
  endtask

  initial begin
    bus_if.address      = IDLE_ADDR;
    bus_if.wr_data      = '0;
    bus_if.write_enable = 1'b0;
    test_reset();
    test_pins();
    test_unmapped();
    test_counter();
    test_snapshot();
    test_alarm();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
